// File: rtl/pet_memory_map_pkg.sv
// Shared constants for the PET memory-map decoder: region flag layout, base-map
// address landmarks and the bit positions inside the bank control register.
package pet_memory_map_pkg;

    localparam int CTRL_WIDTH = 8;

    localparam int FLAG_RAM      = 0;
    localparam int FLAG_PIA1     = 1;
    localparam int FLAG_PIA2     = 2;
    localparam int FLAG_VIA      = 3;
    localparam int FLAG_CRTC     = 4;
    localparam int FLAG_IO       = 5;
    localparam int FLAG_MIRRORED = 6;
    localparam int FLAG_READONLY = 7;
    localparam int NUM_FLAGS     = 8;

    typedef logic [NUM_FLAGS-1:0] region_flags_t;

    // Complete flag sets per region; every IO chip also raises the shared io flag.
    localparam region_flags_t FLAGS_RAM  = 8'b0000_0001;
    localparam region_flags_t FLAGS_VRAM = 8'b0100_0001;
    localparam region_flags_t FLAGS_ROM  = 8'b1000_0001;
    localparam region_flags_t FLAGS_PIA1 = 8'b0010_0010;
    localparam region_flags_t FLAGS_PIA2 = 8'b0010_0100;
    localparam region_flags_t FLAGS_VIA  = 8'b0010_1000;
    localparam region_flags_t FLAGS_CRTC = 8'b0011_0000;

    localparam logic [15:0] VRAM_BASE      = 16'h8000;
    localparam logic [15:0] VRAM_END       = 16'h8FFF;
    localparam logic [15:0] IO_PAGE_SIZE   = 16'h0100;
    localparam logic [15:0] IO_WINDOW_SIZE = 16'h0800;
    localparam logic [7:0]  PIA1_OFFSET    = 8'h10;
    localparam logic [7:0]  PIA2_OFFSET    = 8'h20;
    localparam logic [7:0]  VIA_OFFSET     = 8'h40;
    localparam logic [7:0]  CRTC_OFFSET    = 8'h80;

    localparam int CTRL_EXPAND      = 7;
    localparam int CTRL_IO_PEEK     = 6;
    localparam int CTRL_SCREEN_PEEK = 5;
    localparam int CTRL_BANK_HI     = 3;
    localparam int CTRL_BANK_LO     = 2;
    localparam int CTRL_PROTECT_HI  = 1;
    localparam int CTRL_PROTECT_LO  = 0;

endpackage

// File: rtl/banked_address_decoder_bank_ctrl_reg.sv
// Write-only bank control register; loads write_data when the qualified
// control write is presented, otherwise holds.
module bank_ctrl_reg
    import pet_memory_map_pkg::*;
#(
    parameter logic [CTRL_WIDTH-1:0] RESET_VALUE = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [CTRL_WIDTH-1:0] write_data,
    output logic [CTRL_WIDTH-1:0] ctrl_value
);

    logic [CTRL_WIDTH-1:0] value_d;
    logic [CTRL_WIDTH-1:0] value_q;

    always_comb begin
        value_d = value_q;
        if (write_en) begin
            value_d = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign ctrl_value = value_q;

endmodule

// File: rtl/banked_address_decoder.sv
// Registered PET memory-map decoder with 8096-style expansion banking: one
// combinational decode feeding a single output register stage.
module banked_address_decoder
    import pet_memory_map_pkg::*;
#(
    parameter logic [15:0] CTRL_ADDR    = 16'hFFF0,
    parameter logic [15:0] IO_BASE      = 16'hE800,
    parameter int          EXPANSION_EN = 1,
    parameter logic [7:0]  CTRL_RESET   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_data,
    output logic [16:0] ram_addr,
    output logic        ram_enable,
    output logic        pia1_enable,
    output logic        pia2_enable,
    output logic        via_enable,
    output logic        crtc_enable,
    output logic        io_enable,
    output logic        is_mirrored,
    output logic        is_readonly,
    output logic        decode_valid,
    output logic [7:0]  bank_ctrl
);

    logic          ctrl_write;
    logic [15:0]   io_offset;
    logic          in_vram;
    logic          in_io_page;
    logic          in_io_window;
    logic          hi_half;
    logic          remap;
    logic [16:0]   dec_addr;
    region_flags_t dec_flags;

    logic [16:0]   ram_addr_d, ram_addr_q;
    region_flags_t flags_d, flags_q;
    logic          valid_d, valid_q;

    assign ctrl_write = strobe && cpu_we && (cpu_addr == CTRL_ADDR) && (EXPANSION_EN != 0);

    bank_ctrl_reg #(
        .RESET_VALUE(CTRL_RESET)
    ) u_bank_ctrl_reg (
        .clk       (clk),
        .reset     (reset),
        .write_en  (ctrl_write),
        .write_data(cpu_data),
        .ctrl_value(bank_ctrl)
    );

    assign io_offset    = cpu_addr - IO_BASE;
    assign in_vram      = (cpu_addr >= VRAM_BASE) && (cpu_addr <= VRAM_END);
    assign in_io_page   = (cpu_addr >= IO_BASE) && (io_offset < IO_PAGE_SIZE);
    assign in_io_window = (cpu_addr >= IO_BASE) && (io_offset < IO_WINDOW_SIZE);
    assign hi_half      = cpu_addr[14];

    // Peek-through bits punch the screen and IO holes back into the base map.
    assign remap = bank_ctrl[CTRL_EXPAND] && cpu_addr[15]
                && !(bank_ctrl[CTRL_SCREEN_PEEK] && in_vram)
                && !(bank_ctrl[CTRL_IO_PEEK] && in_io_window);

    always_comb begin
        dec_addr  = {1'b0, cpu_addr};
        dec_flags = FLAGS_ROM;
        if (remap) begin
            dec_addr  = {1'b1, hi_half ? bank_ctrl[CTRL_BANK_HI] : bank_ctrl[CTRL_BANK_LO],
                         cpu_addr[14:0]};
            dec_flags = FLAGS_RAM;
            dec_flags[FLAG_READONLY] = hi_half ? bank_ctrl[CTRL_PROTECT_HI]
                                               : bank_ctrl[CTRL_PROTECT_LO];
        end else if (!cpu_addr[15]) begin
            dec_flags = FLAGS_RAM;
        end else if (in_vram) begin
            dec_flags = FLAGS_VRAM;
        end else if (in_io_page) begin
            if (io_offset[7:0] < PIA1_OFFSET) begin
                dec_flags = FLAGS_RAM;
            end else if (io_offset[7:0] < PIA2_OFFSET) begin
                dec_flags = FLAGS_PIA1;
            end else if (io_offset[7:0] < VIA_OFFSET) begin
                dec_flags = FLAGS_PIA2;
            end else if (io_offset[7:0] < CRTC_OFFSET) begin
                dec_flags = FLAGS_VIA;
            end else begin
                dec_flags = FLAGS_CRTC;
            end
        end
    end

    always_comb begin
        valid_d    = strobe;
        ram_addr_d = ram_addr_q;
        flags_d    = flags_q;
        if (strobe) begin
            ram_addr_d = dec_addr;
            flags_d    = dec_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ram_addr_q <= '0;
            flags_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            ram_addr_q <= ram_addr_d;
            flags_q    <= flags_d;
        end
    end

    assign decode_valid = valid_q;
    assign ram_addr     = ram_addr_q;
    assign ram_enable   = flags_q[FLAG_RAM];
    assign pia1_enable  = flags_q[FLAG_PIA1];
    assign pia2_enable  = flags_q[FLAG_PIA2];
    assign via_enable   = flags_q[FLAG_VIA];
    assign crtc_enable  = flags_q[FLAG_CRTC];
    assign io_enable    = flags_q[FLAG_IO];
    assign is_mirrored  = flags_q[FLAG_MIRRORED];
    assign is_readonly  = flags_q[FLAG_READONLY];

endmodule

// File: tb/tb_banked_address_decoder.sv
// Self-checking bench: directed PET map cases plus randomized accesses against an
// arithmetic reference model, on an expansion-enabled and an expansion-disabled decoder.
module tb_banked_address_decoder;

    typedef struct packed {
        logic [16:0] addr;
        logic        ram;
        logic        pia1;
        logic        pia2;
        logic        via;
        logic        crtc;
        logic        io;
        logic        mir;
        logic        ro;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [15:0] cpuAddr;
    logic        cpuWe;
    logic [7:0]  cpuData;

    logic [16:0] ramAddrA, ramAddrB;
    logic        ramEnA, pia1A, pia2A, viaA, crtcA, ioA, mirA, roA, validA;
    logic        ramEnB, pia1B, pia2B, viaB, crtcB, ioB, mirB, roB, validB;
    logic [7:0]  ctrlA, ctrlB;

    int   passCount = 0;
    int   checkCount = 0;
    logic [7:0] ctrlModelA;
    exp_t lastA, lastB;

    always #5 clk = ~clk;

    banked_address_decoder dut (
        .clk(clk), .reset(reset), .strobe(strobe), .cpu_addr(cpuAddr), .cpu_we(cpuWe),
        .cpu_data(cpuData), .ram_addr(ramAddrA), .ram_enable(ramEnA), .pia1_enable(pia1A),
        .pia2_enable(pia2A), .via_enable(viaA), .crtc_enable(crtcA), .io_enable(ioA),
        .is_mirrored(mirA), .is_readonly(roA), .decode_valid(validA), .bank_ctrl(ctrlA)
    );

    banked_address_decoder #(.EXPANSION_EN(0)) dutNoExp (
        .clk(clk), .reset(reset), .strobe(strobe), .cpu_addr(cpuAddr), .cpu_we(cpuWe),
        .cpu_data(cpuData), .ram_addr(ramAddrB), .ram_enable(ramEnB), .pia1_enable(pia1B),
        .pia2_enable(pia2B), .via_enable(viaB), .crtc_enable(crtcB), .io_enable(ioB),
        .is_mirrored(mirB), .is_readonly(roB), .decode_valid(validB), .bank_ctrl(ctrlB)
    );

    wire [24:0] actA = {ramAddrA, ramEnA, pia1A, pia2A, viaA, crtcA, ioA, mirA, roA};
    wire [24:0] actB = {ramAddrB, ramEnB, pia1B, pia2B, viaB, crtcB, ioB, mirB, roB};

    // Reference map written directly from the address ranges, not from the RTL structure.
    function automatic exp_t refDecode(input logic [15:0] addr, input logic [7:0] ctrl);
        exp_t e;
        int   a;
        int   off;
        int   bank;
        bit   hi;
        e = '0;
        a = int'(addr);
        e.addr = 17'(a);
        if (ctrl[7] && a >= 'h8000 && !(ctrl[5] && a < 'h9000)
            && !(ctrl[6] && a >= 'hE800 && a < 'hF000)) begin
            hi   = (a >= 'hC000);
            bank = hi ? int'(ctrl[3]) : int'(ctrl[2]);
            e.addr = 17'('h10000 + bank * 'h8000 + a % 'h8000);
            e.ram  = 1'b1;
            e.ro   = hi ? ctrl[1] : ctrl[0];
        end else if (a < 'h8000) begin
            e.ram = 1'b1;
        end else if (a < 'h9000) begin
            e.ram = 1'b1;
            e.mir = 1'b1;
        end else if (a >= 'hE800 && a < 'hE900) begin
            off = a - 'hE800;
            if (off < 'h10) begin
                e.ram = 1'b1;
            end else if (off < 'h20) begin
                e.pia1 = 1'b1;
                e.io   = 1'b1;
            end else if (off < 'h40) begin
                e.pia2 = 1'b1;
                e.io   = 1'b1;
            end else if (off < 'h80) begin
                e.via = 1'b1;
                e.io  = 1'b1;
            end else begin
                e.crtc = 1'b1;
                e.io   = 1'b1;
            end
        end else begin
            e.ram = 1'b1;
            e.ro  = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Presents one access at a falling edge and checks the registered result one cycle later;
    // strobe is left high so back-to-back calls form consecutive strobes.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data,
                                 input string tag);
        exp_t expA;
        exp_t expB;
        expA    = refDecode(addr, ctrlModelA);
        expB    = refDecode(addr, 8'h00);
        strobe  = 1'b1;
        cpuAddr = addr;
        cpuWe   = we;
        cpuData = data;
        @(negedge clk);
        checkOutput({tag, "/validA"}, 32'(validA), 32'd1);
        checkOutput({tag, "/decodeA"}, 32'(actA), 32'(expA));
        checkOutput({tag, "/validB"}, 32'(validB), 32'd1);
        checkOutput({tag, "/decodeB"}, 32'(actB), 32'(expB));
        if (we && addr == 16'hFFF0) begin
            ctrlModelA = data;
        end
        checkOutput({tag, "/ctrlA"}, 32'(ctrlA), 32'(ctrlModelA));
        checkOutput({tag, "/ctrlB"}, 32'(ctrlB), 32'h00);
        lastA = expA;
        lastB = expB;
    endtask

    task automatic idleCycle(input string tag);
        strobe = 1'b0;
        cpuWe  = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/idleValidA"}, 32'(validA), 32'd0);
        checkOutput({tag, "/holdA"}, 32'(actA), 32'(lastA));
        checkOutput({tag, "/idleValidB"}, 32'(validB), 32'd0);
        checkOutput({tag, "/holdB"}, 32'(actB), 32'(lastB));
    endtask

    initial begin
        logic [15:0] rAddr;
        logic        rWe;
        logic [7:0]  rData;
        reset      = 1'b1;
        strobe     = 1'b0;
        cpuAddr    = 16'h0000;
        cpuWe      = 1'b0;
        cpuData    = 8'h00;
        ctrlModelA = 8'h00;
        lastA      = '0;
        lastB      = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetOutA", 32'(actA), 32'd0);
        checkOutput("resetValidA", 32'(validA), 32'd0);
        checkOutput("resetCtrlA", 32'(ctrlA), 32'h00);
        checkOutput("resetOutB", 32'(actB), 32'd0);
        reset = 1'b0;
        idleCycle("postReset");

        applyStimulus(16'h1234, 1'b0, 8'h00, "ram1234");
        idleCycle("ram1234");
        applyStimulus(16'h8123, 1'b0, 8'h00, "vram");
        applyStimulus(16'hE815, 1'b0, 8'h00, "pia1");
        applyStimulus(16'hE830, 1'b0, 8'h00, "pia2");
        applyStimulus(16'hE850, 1'b0, 8'h00, "via");
        applyStimulus(16'hE8A0, 1'b0, 8'h00, "crtc");
        applyStimulus(16'hF000, 1'b0, 8'h00, "rom");
        applyStimulus(16'hE805, 1'b0, 8'h00, "magic");
        applyStimulus(16'hFFF0, 1'b0, 8'hAA, "ctrlRead");
        idleCycle("base");

        applyStimulus(16'hFFF0, 1'b1, 8'h84, "wr84");
        applyStimulus(16'h9000, 1'b0, 8'h00, "exp9000");
        applyStimulus(16'hC000, 1'b0, 8'h00, "expC000");
        idleCycle("exp84");

        applyStimulus(16'hFFF0, 1'b1, 8'hE3, "wrE3");
        applyStimulus(16'h8010, 1'b0, 8'h00, "screenPeek");
        applyStimulus(16'hE810, 1'b0, 8'h00, "ioPeek");
        applyStimulus(16'hEF00, 1'b0, 8'h00, "ioPeekRom");
        applyStimulus(16'hD000, 1'b0, 8'h00, "protHi");
        applyStimulus(16'hB000, 1'b0, 8'h00, "protLo");
        idleCycle("expE3");

        applyStimulus(16'hFFF0, 1'b1, 8'h80, "wr80");
        applyStimulus(16'hA000, 1'b0, 8'h00, "backToBack");
        idleCycle("wr80");

        for (int i = 0; i < 300; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rData = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rAddr = 16'($urandom_range(16'hE800, 16'hE8FF));
                1: rAddr = 16'($urandom_range(16'h8000, 16'h8FFF));
                2: rAddr = 16'($urandom_range(16'hE900, 16'hEFFF));
                3: begin
                    rAddr = 16'hFFF0;
                    rWe   = 1'($urandom_range(0, 3) != 0);
                end
                4: rAddr = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: rAddr = 16'($urandom);
            endcase
            applyStimulus(rAddr, rWe, rData, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                idleCycle($sformatf("rnd%0d", i));
            end
        end
        idleCycle("rndEnd");

        applyStimulus(16'hFFF0, 1'b1, 8'hFF, "wrFF");
        idleCycle("wrFF");

        applyStimulus(16'hE8A0, 1'b0, 8'h00, "preReset");
        cpuAddr = 16'h1234;
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncResetOutA", 32'(actA), 32'd0);
        checkOutput("asyncResetValidA", 32'(validA), 32'd0);
        checkOutput("asyncResetCtrlA", 32'(ctrlA), 32'h00);
        checkOutput("asyncResetOutB", 32'(actB), 32'd0);
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        ctrlModelA = 8'h00;
        lastA      = '0;
        lastB      = '0;
        idleCycle("droppedDecode");
        applyStimulus(16'hC000, 1'b0, 8'h00, "postResetC000");
        idleCycle("final");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
